// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and the bit-period helper,
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clocks per line bit, truncated toward zero.
  function automatic int cycles_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: one-clock tick every p_cycles_per_bit clocks while
// enabled; held at zero while disabled so each frame starts on a fresh period.
module uart_baud_tick #(
  parameter int p_cycles_per_bit = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CW = $clog2(p_cycles_per_bit) + 1;
  localparam logic [CW-1:0] LAST = CW'(p_cycles_per_bit - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!enable_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional parity, registered tx_o.
// Define UART_TX_STOP2_EN to send two stop bits instead of one.
module uart_tx
  import uart_pkg::*;
#(
  parameter int p_clk_speed_hz = 50_000_000,
  parameter int p_baud_rate    = 9_600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       parity_en_i,
  input  logic       parity_sel_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(p_clk_speed_hz, p_baud_rate);

`ifdef UART_TX_STOP2_EN
  localparam logic [2:0] LAST_STOP = 3'd1;
`else
  localparam logic [2:0] LAST_STOP = 3'd0;
`endif

  uart_state_e state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q;
  logic        par_en_q, par_bit_q;
  logic        tx_q, done_q;
  logic        line_bit, finish, tick, load;

  assign ready_o = enable_i && (state_q == ST_IDLE);
  assign busy_o  = (state_q != ST_IDLE);
  assign load    = ready_o && valid_i;
  assign tx_o    = tx_q;
  assign done_o  = done_q;

  uart_baud_tick #(
    .p_cycles_per_bit(CYCLES_PER_BIT)
  ) u_baud (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .enable_i(busy_o),
    .tick_o  (tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= line_bit;
      done_q    <= finish;
    end
  end

  // Frame fields are captured at the transfer so the source may move on at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else if (load) begin
      shreg_q   <= data_i;
      par_en_q  <= parity_en_i;
      par_bit_q <= parity_sel_i ? ^data_i : ~^data_i;
    end else if (state_q == ST_DATA && tick) begin
      shreg_q <= {1'b0, shreg_q[7:1]};
    end
  end

  // line_bit is the level of the current state; tx_q shows it one clock later,
  // which also lines done_o up with the last cycle of the stop bit on the wire.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    line_bit  = 1'b1;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (load) state_d = ST_START;
      end
      ST_START: begin
        line_bit = 1'b0;
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        line_bit = shreg_q[0];
        if (tick) begin
          if (bit_cnt_q == 3'd7) begin
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        line_bit = par_bit_q;
        if (tick) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        line_bit = 1'b1;
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            finish    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        line_bit  = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter p_clk_speed_hz, default 50_000_000, the clk_i frequency in Hz.
REQ-002 SHALL have parameter p_baud_rate, default 9_600, the line bit rate.
REQ-003 SHALL have clk_i  input  1  system clock; all state is on the rising edge.
REQ-004 SHALL have rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have enable_i  input  1  when high, a new frame may be accepted; when low, the block stays idle.
REQ-006 SHALL have data_i  input  8  byte to transmit.
REQ-007 SHALL have valid_i  input  1  data_i is offered.
REQ-008 SHALL have ready_o  output  1  the block accepts data_i; a transfer occurs when valid_i && ready_o on a clock edge.
REQ-009 SHALL have parity_en_i  input  1  append a parity bit.
REQ-010 SHALL have parity_sel_i  input  1  parity type: 1 means parity bit = ^data; 0 means parity bit = ~^data.
REQ-011 SHALL have tx_o  output  1  serial line; idle high.
REQ-012 SHALL have busy_o  output  1  a frame is in progress.
REQ-013 SHALL have done_o  output  1  one-cycle pulse at the end of the last stop bit.

Function
REQ-014 SHALL use CYCLES_PER_BIT = p_clk_speed_hz / p_baud_rate, with integer truncation; the counter width SHALL be $clog2(CYCLES_PER_BIT)+1.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
- Transitions: IDLE->START on a transfer; START->DATA; DATA->(parity_en ? PARITY : STOP) after bit 7; PARITY->STOP; STOP->IDLE.
REQ-016 SHALL hold each line bit for exactly CYCLES_PER_BIT clocks.
- The bit counter resets to 0 on each state/bit change.
REQ-017 SHALL latch data_i, parity_en_i and parity_sel_i on the transfer edge; later changes SHALL NOT affect the current frame.
REQ-018 SHALL drive tx_o low (start bit) from the clock edge following the transfer edge (latency 1 clock).
REQ-019 SHALL send the data bits LSB first (bit 0 first), then the optional parity bit, then the stop bit(s) at 1.
REQ-020 SHALL register tx_o (no combinational path from any input to tx_o).
REQ-021 SHALL assert ready_o = enable_i && (state == IDLE); ready_o SHALL be low in every other state.
REQ-022 SHALL ignore valid_i while ready_o is low; there is no buffering, and the source holds data_i/valid_i until the transfer.
REQ-023 SHALL assert busy_o = (state != IDLE).
REQ-024 SHALL pulse done_o high for exactly one clock, in the last cycle of the final stop bit; the following cycle the state SHALL be IDLE.
REQ-025 SHALL complete the current frame if enable_i deasserts mid-frame; no new frame starts until enable_i is high again.
REQ-026 SHALL put back-to-back frames at least one IDLE cycle apart (stop bit, then IDLE, then start bit).
REQ-027 SHALL treat undefined state encodings as IDLE on the next clock, with tx_o = 1.

Reset
REQ-028 SHALL, while rst_i is high, immediately and asynchronously force:
- state = IDLE, tx_o = 1, busy_o = 0, done_o = 0;
- bit/cycle counters = 0, data shift register = 0.
REQ-029 SHALL abort a frame in progress when reset is asserted mid-frame, with no done_o pulse; ready_o follows enable_i from the first clock after rst_i deasserts.

Configuration
REQ-030 SHALL support the macro UART_TX_STOP2_EN.
- Defined: STOP lasts 2 x CYCLES_PER_BIT clocks (two stop bits), and done_o fires at the end of the second.
- Undefined: exactly one stop bit.

Structure
REQ-031 SHALL place the state encoding constants (3-bit) and a cycles-per-bit helper function in the shared package uart_pkg, used by both uart_tx and the receiver.
REQ-032 SHALL instantiate one sub-module, uart_baud_tick.
- Its role: the bit-period counter, emitting a one-clock tick every CYCLES_PER_BIT clocks while its enable is high, and clearing while its enable is low.

Verification (p_clk_speed_hz=1_000_000, p_baud_rate=100_000, so CYCLES_PER_BIT=10)
REQ-033 SHALL cover, with parity off, data_i=8'hA5 transferred at edge T.
- tx_o low for clocks T+1..T+10.
- Then bits 1,0,1,0,0,1,0,1 for 10 clocks each, then high for 10 clocks.
- done_o is high at clock T+100 only.
REQ-034 SHALL cover parity on, parity_sel_i=1, data_i=8'h07: the parity bit is 1.
- Repeat with parity_sel_i=0: the parity bit is 0.
- The frame is 110 clocks.
REQ-035 SHALL cover valid_i held high continuously with two bytes 8'h55 then 8'hAA.
- The second transfer occurs exactly one clock after done_o.
- ready_o stays low throughout the first frame.
REQ-036 SHALL cover rst_i pulsed at clock T+35 of a frame.
- tx_o = 1 and busy_o = 0 in the same cycle.
- No done_o pulse.
- The next transfer sends a correct full frame.
REQ-037 SHALL cover enable_i dropped at clock T+20.
- The frame completes normally.
- ready_o stays 0 while enable_i = 0.
REQ-038 SHALL cover, with UART_TX_STOP2_EN defined, data_i=8'h00 and parity off: tx_o high for 20 clocks after the data bits, and done_o at T+110.
